// File: rtl/bp_nonsynth_pc_histogram_table.sv
// bp_nonsynth_pc_histogram_table: fully associative committed-PC histogram with a valid/yumi dump port
module bp_nonsynth_pc_histogram_table #(
  parameter int vaddr_width_p  = 39,
  parameter int num_channels_p = 2,
  parameter int entries_p      = 16,
  parameter int count_width_p  = 32
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    freeze_i,
  input  logic [num_channels_p-1:0]               commit_v_i,
  input  logic [num_channels_p*vaddr_width_p-1:0] commit_pc_i,
  input  logic                                    dump_i,
  input  logic                                    clear_i,
  output logic                                    dump_v_o,
  output logic [vaddr_width_p-1:0]                dump_pc_o,
  output logic [count_width_p-1:0]                dump_count_o,
  input  logic                                    dump_yumi_i,
  output logic                                    dump_done_o,
  output logic                                    busy_o,
  output logic [count_width_p-1:0]                dropped_o,
  output logic [$clog2(entries_p+1)-1:0]          used_o
);
  localparam int ptr_w = $clog2(entries_p);
  localparam int used_w = $clog2(entries_p+1);
  localparam logic [count_width_p-1:0] one_c = count_width_p'(1);
  localparam logic [ptr_w-1:0] last_c = ptr_w'(entries_p-1);
  typedef enum logic [1:0] {e_count, e_dump, e_done} state_e;
  state_e state;
  logic run;
  logic [entries_p-1:0] valid, valid_n;
  logic [vaddr_width_p-1:0] pc [entries_p];
  logic [vaddr_width_p-1:0] pc_n [entries_p];
  logic [count_width_p-1:0] cnt [entries_p];
  logic [count_width_p-1:0] cnt_n [entries_p];
  logic [count_width_p-1:0] dropped, dropped_n;
  logic [ptr_w-1:0] ptr;
  logic clear, accept, hit, alloc;
  assign clear = clear_i && state != e_dump;
  assign accept = state == e_count && !freeze_i && !clear;
  // Apply each valid channel in ascending order on top of the previous channel's result
  always_comb begin
    valid_n = valid;
    pc_n = pc;
    cnt_n = cnt;
    dropped_n = dropped;
    hit = 1'b0;
    alloc = 1'b0;
    for (int c = 0; c < num_channels_p; c++) begin
      if (accept && commit_v_i[c]) begin
        hit = 1'b0;
        alloc = 1'b0;
        for (int e = 0; e < entries_p; e++) begin
          if (valid_n[e] && pc_n[e] == commit_pc_i[c*vaddr_width_p +: vaddr_width_p]) begin
            hit = 1'b1;
            cnt_n[e] = &cnt_n[e] ? cnt_n[e] : cnt_n[e] + one_c;
          end
        end
        for (int e = 0; e < entries_p; e++) begin
          if (!hit && !alloc && !valid_n[e]) begin
            alloc = 1'b1;
            valid_n[e] = 1'b1;
            pc_n[e] = commit_pc_i[c*vaddr_width_p +: vaddr_width_p];
            cnt_n[e] = one_c;
          end
        end
        dropped_n = (!hit && !alloc && !(&dropped_n)) ? dropped_n + one_c : dropped_n;
      end
    end
    if (clear) begin
      valid_n = '0;
      dropped_n = '0;
    end
  end
  // Single-stage release gate: the first table/FSM update lands on the second edge after reset release
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) run <= 1'b0;
    else run <= 1'b1;
  end
  // Table, drop counter and dump-scan FSM
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= e_count;
      valid <= '0;
      dropped <= '0;
      ptr <= '0;
      for (int e = 0; e < entries_p; e++) begin
        pc[e] <= '0;
        cnt[e] <= '0;
      end
    end else if (run) begin
      valid <= valid_n;
      pc <= pc_n;
      cnt <= cnt_n;
      dropped <= dropped_n;
      case (state)
        e_count: if (!clear && dump_i) begin
          state <= e_dump;
          ptr <= '0;
        end
        e_dump: if (!valid[ptr] || dump_yumi_i) begin
          ptr <= ptr + ptr_w'(1);
          if (ptr == last_c) state <= e_done;
        end
        e_done: if (clear) state <= e_count;
        default: state <= e_count;
      endcase
    end
  end
  // Count of occupied entries
  always_comb begin
    used_o = '0;
    for (int e = 0; e < entries_p; e++) used_o = used_o + used_w'(valid[e]);
  end
  assign dump_v_o = state == e_dump && valid[ptr];
  assign dump_pc_o = dump_v_o ? pc[ptr] : '0;
  assign dump_count_o = dump_v_o ? cnt[ptr] : '0;
  assign dump_done_o = state == e_done;
  assign busy_o = state == e_dump;
  assign dropped_o = dropped;
endmodule

// File: tb/tb_bp_nonsynth_pc_histogram_table.sv
// tb_bp_nonsynth_pc_histogram_table: scoreboard bench for the PC histogram table
module tb_bp_nonsynth_pc_histogram_table;
  localparam int W = 39, N = 2, E = 16, C = 32;
  logic clk = 0, reset_n = 0, freeze = 0, dump = 0, clear = 0, yumi = 0;
  logic [N-1:0] cv = '0;
  logic [N*W-1:0] cpc = '0;
  logic dump_v, done, busy;
  logic [W-1:0] dump_pc;
  logic [C-1:0] dump_cnt, dropped;
  logic [$clog2(E+1)-1:0] used;
  logic c4_v = 0, c4_dump = 0, c4_yumi = 0;
  logic [15:0] c4_pc = 16'habc;
  logic c4_dump_v, c4_done, c4_busy;
  logic [15:0] c4_dump_pc;
  logic [3:0] c4_cnt, c4_dropped;
  logic [1:0] c4_used;
  int errors = 0, checks = 0;
  typedef struct {logic [W-1:0] pc; logic [C-1:0] cnt;} rec_t;
  rec_t q[$];
  logic mv [E];
  logic [W-1:0] mpc [E];
  logic [C-1:0] mcnt [E];
  logic [C-1:0] mdrop;

  bp_nonsynth_pc_histogram_table #(.vaddr_width_p(W), .num_channels_p(N), .entries_p(E), .count_width_p(C)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze), .commit_v_i(cv), .commit_pc_i(cpc),
    .dump_i(dump), .clear_i(clear), .dump_v_o(dump_v), .dump_pc_o(dump_pc), .dump_count_o(dump_cnt),
    .dump_yumi_i(yumi), .dump_done_o(done), .busy_o(busy), .dropped_o(dropped), .used_o(used));

  bp_nonsynth_pc_histogram_table #(.vaddr_width_p(16), .num_channels_p(1), .entries_p(2), .count_width_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(1'b0), .commit_v_i(c4_v), .commit_pc_i(c4_pc),
    .dump_i(c4_dump), .clear_i(1'b0), .dump_v_o(c4_dump_v), .dump_pc_o(c4_dump_pc), .dump_count_o(c4_cnt),
    .dump_yumi_i(c4_yumi), .dump_done_o(c4_done), .busy_o(c4_busy), .dropped_o(c4_dropped), .used_o(c4_used));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int m_used();
    int n = 0;
    for (int e = 0; e < E; e++) n += int'(mv[e]);
    return n;
  endfunction

  function automatic void m_apply(input logic [W-1:0] p);
    bit placed = 0;
    for (int e = 0; e < E; e++)
      if (mv[e] && mpc[e] == p) begin
        placed = 1;
        if (mcnt[e] != '1) mcnt[e]++;
      end
    for (int e = 0; e < E; e++)
      if (!placed && !mv[e]) begin
        placed = 1;
        mv[e] = 1;
        mpc[e] = p;
        mcnt[e] = 1;
      end
    if (!placed && mdrop != '1) mdrop++;
  endfunction

  function automatic void m_clear();
    for (int e = 0; e < E; e++) mv[e] = 0;
    mdrop = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [N-1:0] v, input logic [W-1:0] p0, input logic [W-1:0] p1);
    cv = v;
    cpc = {p1, p0};
    tick();
    cv = '0;
    if (v[0]) m_apply(p0);
    if (v[1]) m_apply(p1);
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
    m_clear();
    chk("clear_used", 64'(used), 0);
    chk("clear_dropped", 64'(dropped), 0);
    chk("clear_done", 64'(done), 0);
  endtask

  task automatic dump_run(input int stall, output int n);
    rec_t r;
    for (int e = 0; e < E; e++) if (mv[e]) q.push_back('{mpc[e], mcnt[e]});
    dump = 1;
    tick();
    dump = 0;
    n = 0;
    chk("dump_busy", 64'(busy), 1);
    while (!done && n < 200) begin
      if (dump_v) begin
        if (q.size() == 0) chk("dump_extra_record", 64'(dump_v), 0);
        else begin
          r = q.pop_front();
          chk("dump_pc", 64'(dump_pc), 64'(r.pc));
          chk("dump_count", 64'(dump_cnt), 64'(r.cnt));
          for (int i = 0; i < stall; i++) begin
            cv = '1;
            cpc = {W'(32'h9100 + i), W'(32'h9000 + i)};
            tick();
            chk("stall_pc", 64'(dump_pc), 64'(r.pc));
            chk("stall_count", 64'(dump_cnt), 64'(r.cnt));
            chk("stall_used", 64'(used), 64'(m_used()));
          end
          cv = '0;
          stall = 0;
        end
        yumi = 1;
        tick();
        yumi = 0;
      end else tick();
      n++;
    end
    chk("dump_done", 64'(done), 1);
    chk("dump_records_left", 64'(q.size()), 0);
    chk("dump_busy_end", 64'(busy), 0);
    chk("dump_keeps_used", 64'(used), 64'(m_used()));
    chk("dump_keeps_dropped", 64'(dropped), 64'(mdrop));
    q.delete();
  endtask

  initial begin
    int n;
    m_clear();
    #12;
    chk("rst_dump_v", 64'(dump_v), 0);
    chk("rst_dump_pc", 64'(dump_pc), 0);
    chk("rst_dump_count", 64'(dump_cnt), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_used", 64'(used), 0);
    chk("rst_dropped", 64'(dropped), 0);
    tick();
    reset_n = 1;
    cv = 2'b01;
    cpc = {W'(0), W'(32'h55)};
    tick();
    chk("sync_first_edge", 64'(used), 0);
    tick();
    cv = '0;
    m_apply(W'(32'h55));
    chk("sync_second_edge", 64'(used), 1);
    do_clear();

    c4_v = 1;
    repeat (20) tick();
    c4_v = 0;
    c4_dump = 1;
    tick();
    c4_dump = 0;
    n = 0;
    while (!c4_dump_v && n < 10) begin tick(); n++; end
    chk("sat_valid", 64'(c4_dump_v), 1);
    chk("sat_pc", 64'(c4_dump_pc), 64'h abc);
    chk("sat_count", 64'(c4_cnt), 64'hf);
    c4_yumi = 1;
    tick();
    c4_yumi = 0;
    n = 0;
    while (!c4_done && n < 10) begin tick(); n++; end
    chk("sat_done", 64'(c4_done), 1);

    repeat (3) commit(2'b01, W'(32'h1000), W'(0));
    dump_run(0, n);
    do_clear();

    commit(2'b11, W'(32'h2000), W'(32'h2000));
    chk("dup_used", 64'(used), 1);
    dump_run(0, n);
    do_clear();

    freeze = 1;
    cv = 2'b11;
    cpc = {W'(32'h7001), W'(32'h7000)};
    tick();
    cv = '0;
    freeze = 0;
    chk("freeze_used", 64'(used), 0);

    for (int i = 0; i < 9; i++) commit(i == 8 ? 2'b01 : 2'b11, W'(32'h3000 + 2*i), W'(32'h3001 + 2*i));
    chk("full_used", 64'(used), 16);
    chk("full_dropped", 64'(dropped), 1);
    commit(2'b11, W'(32'h3000), W'(32'h3020));
    chk("full_hit_and_drop", 64'(dropped), 2);
    dump_run(5, n);
    do_clear();

    dump_run(0, n);
    chk("empty_dump_cycles", 64'(n), 16);
    do_clear();

    commit(2'b01, W'(32'h4000), W'(0));
    clear = 1;
    dump = 1;
    cv = 2'b11;
    cpc = {W'(32'h4002), W'(32'h4001)};
    tick();
    clear = 0;
    dump = 0;
    cv = '0;
    m_clear();
    chk("clear_wins_busy", 64'(busy), 0);
    chk("clear_wins_used", 64'(used), 0);

    commit(2'b11, W'(32'h5000), W'(32'h5001));
    commit(2'b01, W'(32'h5002), W'(0));
    dump = 1;
    tick();
    dump = 0;
    chk("mid_dump_busy", 64'(busy), 1);
    chk("mid_dump_valid", 64'(dump_v), 1);
    reset_n = 0;
    #1;
    chk("abort_dump_v", 64'(dump_v), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_used", 64'(used), 0);
    chk("abort_dump_pc", 64'(dump_pc), 0);
    tick();
    chk("abort_hold_v", 64'(dump_v), 0);
    reset_n = 1;
    tick();
    tick();
    m_clear();
    chk("post_rst_used", 64'(used), 0);
    chk("post_rst_dropped", 64'(dropped), 0);
    chk("post_rst_done", 64'(done), 0);
    commit(2'b10, W'(0), W'(32'h6000));
    dump_run(0, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bp_nonsynth_pc_histogram_table.md
BP_NONSYNTH_PC_HISTOGRAM_TABLE -- requirements
Module: bp_nonsynth_pc_histogram_table

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39: width of committed PC.
REQ-002 SHALL have parameter num_channels_p, default 2, legal 1..4: commit channels per cycle.
REQ-003 SHALL have parameter entries_p, default 16, power of 2, >= 2: fully associative table depth.
REQ-004 SHALL have parameter count_width_p, default 32: width of per-entry and drop counters.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk_i input 1 (rising-edge), then reset_n_i input 1.
REQ-006 SHALL have freeze_i input 1: when high, commits are ignored.
REQ-007 SHALL have commit_v_i input num_channels_p: per-channel commit valid.
REQ-008 SHALL have commit_pc_i input num_channels_p*vaddr_width_p: channel c PC in bits [c*vaddr_width_p +: vaddr_width_p].
REQ-009 SHALL have dump_i input 1: single-cycle dump request.
REQ-010 SHALL have clear_i input 1: single-cycle table clear request.
REQ-011 SHALL have dump_v_o output 1, dump_pc_o output vaddr_width_p, dump_count_o output count_width_p: dump record, valid/yumi handshake.
REQ-012 SHALL have dump_yumi_i input 1: consumer accepts the current record; legal only while dump_v_o is high.
REQ-013 SHALL have dump_done_o output 1, busy_o output 1, dropped_o output count_width_p, used_o output clog2(entries_p+1).

Function
REQ-014 SHALL implement FSM states e_count, e_dump, e_done; reset state e_count.
REQ-015 In e_count, commits SHALL update the table when freeze_i is low; commits in e_dump or e_done, or while freeze_i is high, SHALL be discarded and not counted as dropped.
REQ-016 Within one cycle, valid channels SHALL be applied in ascending channel index, with the same result as sequential application.
REQ-017 PC hit SHALL increment that entry's count by 1 per matching channel, saturating at all-ones.
REQ-018 PC miss with a free entry SHALL allocate the lowest-index free entry with count 1. Same-cycle distinct misses SHALL take successive lowest free entries. A PC repeated across channels in one cycle SHALL occupy a single entry.
REQ-019 PC miss with the table full (including fill by earlier channels in the same cycle) SHALL increment dropped_o by 1, saturating.
REQ-020 Table updates SHALL be visible on the next cycle: one-cycle latency to used_o and to dump contents.
REQ-021 used_o SHALL equal the number of valid entries.
REQ-022 dump_i in e_count SHALL move the FSM to e_dump on the next edge, with the scan pointer set to 0. That cycle's commits SHALL still be applied. dump_i in other states SHALL be ignored.
REQ-023 In e_dump, the scan pointer SHALL skip invalid entries at 1 entry per cycle. At a valid entry, dump_v_o SHALL be high with that entry's pc/count, held stable until dump_yumi_i.
REQ-024 On dump_yumi_i, the scan pointer SHALL advance. After the last index is accepted or skipped, the FSM SHALL enter e_done.
REQ-025 Dumping SHALL NOT modify entry contents or dropped_o.
REQ-026 In e_done, dump_done_o SHALL be 1. It SHALL be 0 in all other states.
REQ-027 clear_i in e_done or e_count SHALL invalidate all entries, zero dropped_o, and enter e_count next cycle. clear_i in e_dump SHALL be ignored.
REQ-028 If clear_i and dump_i are both high in e_count, clear_i SHALL win and that cycle's commits SHALL be discarded.
REQ-029 busy_o SHALL be 1 in e_dump, else 0.
REQ-030 An empty table dump SHALL reach e_done after entries_p cycles with dump_v_o never asserted.

Reset
REQ-031 reset_n_i low SHALL asynchronously force: state e_count, all entries invalid, scan pointer 0, dropped_o 0.
REQ-032 During reset, outputs SHALL be: dump_v_o 0, dump_pc_o 0, dump_count_o 0, dump_done_o 0, busy_o 0, used_o 0.
REQ-033 Reset asserted mid-dump SHALL abort the dump with no further dump_v_o.
REQ-034 Reset deassertion SHALL be synchronized; the first update SHALL occur on the second rising edge after release.

Verification
REQ-035 Commit PC 0x1000 on ch0 for 3 cycles, then dump with yumi held high -> one record {0x1000, 3}, then dump_done_o=1.
REQ-036 Same cycle: ch0=0x2000, ch1=0x2000 -> one entry, count 2, used_o=1.
REQ-037 entries_p=16: commit 17 distinct PCs, 2 per cycle -> used_o=16, dropped_o=1, 17th PC absent from the dump.
REQ-038 count_width_p=4: commit one PC 20 times -> count 0xF.
REQ-039 During dump, hold dump_yumi_i low 5 cycles -> dump_pc_o/dump_count_o stable, commits ignored, used_o unchanged.
REQ-040 Assert reset_n_i low mid-dump, then clear_i after a completed dump -> both yield used_o=0, dropped_o=0, state e_count.
